// File: rtl/binary_neuron_accum_if.sv
// Stream interface for the binary-weight neuron: an activation/weight beat
// stream in and a per-vector result stream out, each with valid/ready.
interface binary_neuron_accum_if #(
  parameter int LANES  = 16,
  parameter int DATA_W = 8,
  parameter int BEAT_W = 8
) ();

  // Beat stream
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [LANES-1:0]          in_weights;
  logic                      in_last;
  logic                      relu_en;

  // Result stream
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  out_data;
  logic                      out_sat;
  logic [BEAT_W-1:0]         out_beats;

  // Neuron side
  modport slave (
    input  in_valid, in_data, in_weights, in_last, relu_en, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_beats
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_weights, in_last, relu_en, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_beats
  );

endinterface

// File: rtl/binary_neuron_accum.sv
// Pipelined binary-weight neuron. Each beat's lanes are conditionally negated
// by their weight bit, summed in a registered full-precision adder tree, then
// accumulated with saturation across a multi-beat vector ending at in_last.
// The whole pipeline advances together on en = !out_valid || out_ready.
module binary_neuron_accum #(
  parameter int LANES     = 16,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 20,
  parameter int OUT_SHIFT = 0,
  parameter int BEAT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  binary_neuron_accum_if.slave bus
);

  localparam int L     = $clog2(LANES);
  localparam int P_W   = DATA_W + 1;        // product width, holds -(-2^(DATA_W-1))
  localparam int SUM_W = P_W + L;           // width of the tree root
  localparam int AW1   = ACC_W + 1;         // one guard bit for overflow detection

  localparam logic signed [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Global pipeline enable: every stage moves or every stage holds.
  logic en;
  logic out_valid_reg;

  assign en           = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = !rst && en;

  // ---------------------------------------------------------------------------
  // Product stage (level 0) and adder-tree levels 1..L.
  // Level gi holds LANES>>gi partial sums of width P_W+gi, so precision grows
  // by one bit per level and nothing is ever truncated.
  // ---------------------------------------------------------------------------
  genvar gi, gj;
  generate
    for (gi = 0; gi <= L; gi++) begin : g_lvl
      localparam int W = P_W + gi;
      localparam int N = LANES >> gi;

      logic signed [W-1:0] sum_reg  [N];
      logic signed [W-1:0] sum_next [N];
      logic                vld_reg;
      logic                last_reg;
      logic                relu_reg;

      if (gi == 0) begin : g_prod
        for (gj = 0; gj < N; gj++) begin : g_lane
          logic signed [DATA_W-1:0] x;
          assign x            = bus.in_data[gj*DATA_W +: DATA_W];
          // Weight 1 passes the activation, weight 0 negates it in P_W bits.
          assign sum_next[gj] = bus.in_weights[gj] ? W'(x) : -W'(x);
        end

        // Capture products and the beat's sideband flags.
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
            relu_reg <= 1'b0;
          end else if (en) begin
            vld_reg  <= bus.in_valid;
            last_reg <= bus.in_last;
            relu_reg <= bus.relu_en;
            for (int j = 0; j < N; j++) begin
              sum_reg[j] <= sum_next[j];
            end
          end
        end
      end else begin : g_add
        for (gj = 0; gj < N; gj++) begin : g_pair
          assign sum_next[gj] = W'(g_lvl[gi-1].sum_reg[2*gj])
                              + W'(g_lvl[gi-1].sum_reg[2*gj+1]);
        end

        // Register one adder level; flags ride alongside the data.
        always_ff @(posedge clk) begin
          if (rst) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
            relu_reg <= 1'b0;
          end else if (en) begin
            vld_reg  <= g_lvl[gi-1].vld_reg;
            last_reg <= g_lvl[gi-1].last_reg;
            relu_reg <= g_lvl[gi-1].relu_reg;
            for (int j = 0; j < N; j++) begin
              sum_reg[j] <= sum_next[j];
            end
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Accumulate stage
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] a_part;
  logic                    a_vld;
  logic                    a_last;
  logic                    a_relu;

  assign a_part = g_lvl[L].sum_reg[0];
  assign a_vld  = g_lvl[L].vld_reg;
  assign a_last = g_lvl[L].last_reg;
  assign a_relu = g_lvl[L].relu_reg;

  logic signed [ACC_W-1:0]  acc_reg;
  logic [BEAT_W-1:0]        cnt_reg;
  logic                     sticky_reg;
  logic signed [DATA_W-1:0] out_data_reg;
  logic                     out_sat_reg;
  logic [BEAT_W-1:0]        out_beats_reg;

  logic signed [AW1-1:0]    sum_wide;
  logic                     acc_clamp;
  logic signed [ACC_W-1:0]  sum_sat;

  // Add the beat to the running sum and clamp to the accumulator range.
  always_comb begin
    sum_wide  = AW1'(acc_reg) + AW1'(a_part);
    acc_clamp = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
    sum_sat   = sum_wide[ACC_W-1:0];
    if (acc_clamp) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  logic signed [ACC_W-1:0]  shifted;
  logic                     out_clamp;
  logic signed [DATA_W-1:0] res_final;

  // Scale, clamp to the output range, then apply the optional ReLU.
  always_comb begin
    shifted   = sum_sat >>> OUT_SHIFT;
    // In range only when every bit above the output sign bit matches it.
    out_clamp = !((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]));
    res_final = shifted[DATA_W-1:0];
    if (out_clamp) begin
      res_final = shifted[ACC_W-1] ? OUT_MIN : OUT_MAX;
    end
    if (a_relu && res_final[DATA_W-1]) begin
      res_final = '0;
    end
  end

  logic [BEAT_W-1:0] cnt_inc;

  // Beat count sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + BEAT_W'(1);
  end

  // Accumulator, beat counter, sticky flag and the registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sticky_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sat_reg   <= 1'b0;
      out_beats_reg <= '0;
    end else if (en) begin
      // Either a new result lands here or the consumed one retires.
      out_valid_reg <= a_vld && a_last;
      if (a_vld) begin
        if (a_last) begin
          out_data_reg  <= res_final;
          out_sat_reg   <= sticky_reg | acc_clamp | out_clamp;
          out_beats_reg <= cnt_inc;
          // Next vector starts clean on the very next beat.
          acc_reg       <= '0;
          cnt_reg       <= '0;
          sticky_reg    <= 1'b0;
        end else begin
          acc_reg       <= sum_sat;
          cnt_reg       <= cnt_inc;
          sticky_reg    <= sticky_reg | acc_clamp;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_sat   = out_sat_reg;
  assign bus.out_beats = out_beats_reg;

endmodule

// File: tb/tb_binary_neuron_accum.sv
// Bench for binary_neuron_accum: directed vectors, a behavioural scoreboard
// built from the arithmetic rules, and literal pins on key results.
module tb_binary_neuron_accum;

  localparam int LANES     = 16;
  localparam int DATA_W    = 8;
  localparam int ACC_W     = 20;
  localparam int OUT_SHIFT = 0;
  localparam int BEAT_W    = 8;
  localparam int LAT       = $clog2(LANES) + 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  binary_neuron_accum_if #(.LANES(LANES), .DATA_W(DATA_W), .BEAT_W(BEAT_W)) bus ();

  binary_neuron_accum #(
    .LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W),
    .OUT_SHIFT(OUT_SHIFT), .BEAT_W(BEAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint got, input longint exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    $display("FAIL %s: bound expired, got no event expected one", name);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct { longint data; longint sat; longint beats; } res_t;
  res_t   exp_q[$];
  res_t   m_last;
  longint m_acc;
  int     m_cnt;
  bit     m_sticky;

  localparam longint AMAX = (longint'(1) <<< (ACC_W - 1)) - 1;
  localparam longint AMIN = -(longint'(1) <<< (ACC_W - 1));
  localparam longint OMAX = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint OMIN = -(longint'(1) <<< (DATA_W - 1));
  localparam longint BMAX = (longint'(1) <<< BEAT_W) - 1;

  function automatic void model_clear();
    m_acc = 0; m_cnt = 0; m_sticky = 0;
  endfunction

  function automatic void model_beat(input logic [LANES*DATA_W-1:0] d,
                                     input logic [LANES-1:0] w,
                                     input bit last, input bit relu);
    longint part = 0, sum, r, xv;
    logic signed [DATA_W-1:0] xs;
    bit clamp = 0, oc = 0;
    res_t res;
    for (int i = 0; i < LANES; i++) begin
      xs = d[i*DATA_W +: DATA_W];
      xv = xs;
      part += w[i] ? xv : -xv;
    end
    sum = m_acc + part;
    if (sum > AMAX) begin sum = AMAX; clamp = 1; end
    if (sum < AMIN) begin sum = AMIN; clamp = 1; end
    if (last) begin
      r = sum >>> OUT_SHIFT;
      if (r > OMAX) begin r = OMAX; oc = 1; end
      if (r < OMIN) begin r = OMIN; oc = 1; end
      if (relu && r < 0) r = 0;
      res.data  = r;
      res.sat   = (m_sticky | clamp | oc) ? 1 : 0;
      res.beats = (m_cnt + 1 > BMAX) ? BMAX : m_cnt + 1;
      exp_q.push_back(res);
      m_last = res;
      model_clear();
    end else begin
      m_acc = sum;
      m_cnt++;
      m_sticky |= clamp;
    end
  endfunction

  // ---------------- compare process ----------------
  longint got_data_q[$];
  int     got_cyc_q[$];
  longint got_beats_q[$];
  longint got_sat_q[$];
  int     got_count     = 0;
  bit     prev_valid    = 0;
  int     valid_rise_cyc = -1;
  int     last_acc_cyc  = 0;

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (!prev_valid) valid_rise_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        chk("out_data", bus.out_data, exp_q[0].data);
        chk("out_sat", bus.out_sat, exp_q[0].sat);
        chk("out_beats", bus.out_beats, exp_q[0].beats);
        if (bus.out_ready) begin
          void'(exp_q.pop_front());
          got_data_q.push_back(bus.out_data);
          got_sat_q.push_back(bus.out_sat);
          got_beats_q.push_back(bus.out_beats);
          got_cyc_q.push_back(cyc);
          got_count++;
        end
      end
    end
    prev_valid = !rst && bus.out_valid;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [LANES*DATA_W-1:0] rep(input logic [DATA_W-1:0] x);
    logic [LANES*DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = x;
    return v;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] two(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [LANES*DATA_W-1:0] v = '0;
    v[DATA_W-1:0]        = a;
    v[2*DATA_W-1:DATA_W] = b;
    return v;
  endfunction

  function automatic logic [LANES*DATA_W-1:0] pat(input int seed);
    logic [LANES*DATA_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'(i * 37 + seed * 11);
    return v;
  endfunction

  // Tasks start and finish at posedge+1; DUT sampled at negedge.
  task automatic send_beat(input logic [LANES*DATA_W-1:0] d, input logic [LANES-1:0] w,
                           input bit last, input bit relu);
    int t = 0;
    bus.in_valid = 1; bus.in_data = d; bus.in_weights = w;
    bus.in_last = last; bus.relu_en = relu;
    forever begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_beat(d, w, last, relu);
        last_acc_cyc = cyc;
        @(posedge clk); #1;
        bus.in_valid = 0;
        break;
      end
      t++;
      if (t > 200) begin
        fail_now("accept_timeout");
        @(posedge clk); #1;
        bus.in_valid = 0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_results(input int target);
    int t = 0;
    while (got_count < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (got_count < target) fail_now("result_timeout");
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1; bus.in_valid = 0;
    exp_q.delete();
    model_clear();
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_sat", bus.out_sat, 0);
      chk("rst_out_beats", bus.out_beats, 0);
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    rst = 1;
    bus.in_valid = 0; bus.in_data = '0; bus.in_weights = '0;
    bus.in_last = 0; bus.relu_en = 0; bus.out_ready = 1;
    model_clear();
    do_reset(2);

    // All-ones activations, all weights 1: 16, with pipeline latency.
    send_beat(rep(8'd1), 16'hFFFF, 1, 0);
    chk("model_sum16", m_last.data, 16);
    wait_results(1);
    chk("t1_data", got_data_q[0], 16);
    chk("t1_sat", got_sat_q[0], 0);
    chk("t1_beats", got_beats_q[0], 1);
    chk("t1_latency", valid_rise_cyc - last_acc_cyc, LAT);

    // x=3, weights 0: -48, then ReLU to 0.
    send_beat(rep(8'd3), 16'h0000, 1, 0);
    chk("model_neg48", m_last.data, -48);
    wait_results(2);
    chk("t2_data", got_data_q[1], -48);
    send_beat(rep(8'd3), 16'h0000, 1, 1);
    wait_results(3);
    chk("t2_relu_data", got_data_q[2], 0);
    chk("t2_relu_sat", got_sat_q[2], 0);

    // Four beats of 127: acc 8128 saturates the output.
    for (int b = 0; b < 4; b++) send_beat(rep(8'd127), 16'hFFFF, b == 3, 0);
    chk("model_sat127", m_last.data, 127);
    wait_results(4);
    chk("t3_data", got_data_q[3], 127);
    chk("t3_sat", got_sat_q[3], 1);
    chk("t3_beats", got_beats_q[3], 4);

    // Negating -128 is exact (+128 per lane), then output clamps.
    send_beat(rep(8'h80), 16'h0000, 1, 0);
    wait_results(5);
    chk("t4_data", got_data_q[4], 127);
    chk("t4_sat", got_sat_q[4], 1);

    // Back-to-back single-beat vectors 5, -7, 0.
    base = got_count;
    send_beat(two(8'd5, 8'd0), 16'h0001, 1, 0);
    send_beat(two(8'd7, 8'd0), 16'h0000, 1, 0);
    send_beat(two(8'd3, 8'd3), 16'h0001, 1, 0);
    wait_results(base + 3);
    chk("b2b_d0", got_data_q[base], 5);
    chk("b2b_d1", got_data_q[base+1], -7);
    chk("b2b_d2", got_data_q[base+2], 0);
    chk("b2b_gap01", got_cyc_q[base+1] - got_cyc_q[base], 1);
    chk("b2b_gap12", got_cyc_q[base+2] - got_cyc_q[base+1], 1);

    // Two vectors in flight with the consumer stalled for 5 cycles.
    base = got_count;
    bus.out_ready = 0;
    send_beat(two(8'd10, 8'd0), 16'h0001, 1, 0);
    send_beat(two(8'd4, 8'd0), 16'h0001, 0, 0);
    send_beat(two(8'd2, 8'd0), 16'h0000, 1, 0);
    begin
      int t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 20) begin @(negedge clk); t++; end
      if (!bus.out_valid) fail_now("stall_wait");
    end
    repeat (5) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_hold_data", bus.out_data, 10);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1;
    wait_results(base + 2);
    chk("stall_first", got_data_q[base], 10);
    chk("stall_second", got_data_q[base+1], 2);
    chk("stall_second_beats", got_beats_q[base+1], 2);

    // Reset after 2 of 3 beats; only the fresh vector yields a result.
    base = got_count;
    send_beat(rep(8'd1), 16'hFFFF, 0, 0);
    send_beat(rep(8'd1), 16'hFFFF, 0, 0);
    do_reset(1);
    send_beat(two(8'd9, 8'd0), 16'h0001, 1, 0);
    wait_results(base + 1);
    idle(12);
    chk("abort_count", got_count, base + 1);
    chk("abort_data", got_data_q[base], 9);
    chk("abort_beats", got_beats_q[base], 1);

    // 260 beats of +2048: accumulator clamps, beat count sticks at 255.
    base = got_count;
    for (int b = 0; b < 260; b++) send_beat(rep(8'h80), 16'h0000, b == 259, 0);
    chk("model_long_beats", m_last.beats, 255);
    wait_results(base + 1);
    chk("long_data", got_data_q[base], 127);
    chk("long_sat", got_sat_q[base], 1);
    chk("long_beats", got_beats_q[base], 255);

    // Mixed-sign multi-beat vectors checked by the scoreboard.
    base = got_count;
    for (int b = 0; b < 3; b++) send_beat(pat(b), 16'hA5C3, b == 2, 1);
    for (int b = 0; b < 2; b++) send_beat(pat(b + 5), 16'h3C96, b == 1, 0);
    wait_results(base + 2);

    idle(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
